// File: rtl/kws_wb_master.sv
// kws_wb_master
//   Wishbone classic single-transfer initiator. Each command taken on the
//   cmd_* valid/ready channel becomes one WB cycle. The result comes back on
//   the rsp_* valid/ready channel as read data, or as an error if the slave
//   never acknowledged.
//
// Ports
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   cmd_valid/ready           command handshake
//   cmd_we/adr/dat/sel        command fields (write enable, byte address,
//                             write data, byte lane enables)
//   rsp_valid/ready           response handshake
//   rsp_dat, rsp_err          read data (0 for writes and on error), timeout flag
//   wbm_*                     Wishbone master bus
//
// Every output comes straight from a flop, so no input reaches an output
// through combinational logic.
module kws_wb_master #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 256
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_adr,
  input  logic [DW-1:0]   cmd_dat,
  input  logic [DW/8-1:0] cmd_sel,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_dat,
  output logic            rsp_err,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [DW/8-1:0] wbm_sel_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  input  logic            wbm_ack_i,
  input  logic [DW-1:0]   wbm_dat_i
);
  localparam int SW = DW / 8;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_dat_q, rsp_dat_d;
  logic            rsp_err_q, rsp_err_d;
  logic            cyc_q, cyc_d;
  logic            we_q, we_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [DW-1:0]   dat_q, dat_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          we_d        = cmd_we;
          adr_d       = cmd_adr;
          dat_d       = cmd_dat;
          sel_d       = cmd_sel;
          cnt_d       = '0;
          cyc_d       = 1'b1;
          cmd_ready_d = 1'b0;
          state_d     = BUS;
        end else begin
          // cmd_ready is held low through reset and rises on the first
          // cycle afterwards.
          cmd_ready_d = 1'b1;
        end
      end
      BUS: begin
        // The count can reach TIMEOUT at most, which fits in CW bits, because
        // the FSM always leaves BUS once it reaches TIMEOUT-1.
        cnt_d = cnt_q + 1'b1;
        // An ack on the last allowed cycle still counts as normal completion.
        if (wbm_ack_i) begin
          rsp_dat_d   = we_q ? '0 : wbm_dat_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          cyc_d       = 1'b0;
          state_d     = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          cyc_d       = 1'b0;
          state_d     = RESP;
        end
      end
      RESP: begin
        // cmd_ready rises one cycle after the handshake, so a new command
        // cannot be accepted in the same cycle that the response is consumed.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_kws_wb_master.sv
// tb_kws_wb_master
//   Drives commands into kws_wb_master and plays the Wishbone slave, acking
//   after a chosen number of wait cycles. Each response is checked against
//   the transfer rules: the expected error, data and strobe length follow
//   from the wait count and TIMEOUT.
module tb_kws_wb_master;
  localparam int AW = 32, DW = 32, SW = DW / 8, TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_adr;
  logic [DW-1:0] cmd_dat;
  logic [SW-1:0] cmd_sel;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_dat;
  logic          cyc, stb, we_o, ack;
  logic [SW-1:0] sel_o;
  logic [AW-1:0] adr_o;
  logic [DW-1:0] dat_o, dat_i;

  int checks = 0;
  int errors = 0;

  kws_wb_master #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we_o), .wbm_sel_o(sel_o),
    .wbm_adr_o(adr_o), .wbm_dat_o(dat_o), .wbm_ack_i(ack), .wbm_dat_i(dat_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc_step();
    @(posedge clk); @(negedge clk);
  endtask

  // One full transfer. waits = number of wait cycles before the slave acks.
  // A value of TO or more means the slave never acks inside the window.
  task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [SW-1:0] s, input int waits, input logic [DW-1:0] rd,
                      input int hold);
    logic          exp_err;
    int            exp_n, n;
    logic [DW-1:0] exp_dat;
    bit            done;
    exp_err = (waits >= TO);
    exp_n   = exp_err ? TO : waits + 1;
    exp_dat = (exp_err || w) ? '0 : rd;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1; cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s;
    cyc_step();
    // Scramble the command inputs so that a missing latch shows up on the bus.
    cmd_valid = 0; cmd_we = ~w; cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = SW'($urandom);
    n = 0; done = 0;
    for (int g = 0; g < 4 * TO; g++) begin
      if (!cyc) begin done = 1; break; end
      if (n == 0 || n == exp_n - 1) begin
        chk("stb_eq_cyc", stb, 1);
        chk("bus_we", we_o, w);
        chk("bus_adr", adr_o, a);
        chk("bus_dat", dat_o, d);
        chk("bus_sel", sel_o, s);
        chk("cmd_ready_bus", cmd_ready, 0);
      end
      ack   = (n == waits);
      dat_i = ack ? rd : DW'($urandom);
      n++;
      cyc_step();
    end
    ack = 0;
    chk("bus_bounded", done, 1);
    chk("stb_cycles", n, exp_n);
    chk("stb_low", stb, 0);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_err", rsp_err, exp_err);
    chk("rsp_dat", rsp_dat, exp_dat);
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1; rsp_ready = 0; ack = 1'($urandom); dat_i = $urandom;
      cyc_step();
      chk("hold_valid", rsp_valid, 1);
      chk("hold_dat", rsp_dat, exp_dat);
      chk("hold_err", rsp_err, exp_err);
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_cyc", cyc, 0);
    end
    ack = 0; rsp_ready = 1;
    cyc_step();
    rsp_ready = 0; cmd_valid = 0;
    chk("rsp_drop", rsp_valid, 0);
    chk("no_accept_same_cycle", cyc, 0);
    chk("cmd_ready_back", cmd_ready, 1);
  endtask

  initial begin
    logic [DW-1:0] rd;
    rst = 1; cmd_valid = 0; cmd_we = 0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 0; ack = 0; dat_i = '0;
    cyc_step(); cyc_step();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cyc", cyc, 0);
    chk("rst_stb", stb, 0);
    chk("rst_adr", adr_o, 0);
    chk("rst_dat", rsp_dat, 0);
    rst = 0;
    cyc_step();
    chk("ready_after_rst", cmd_ready, 1);

    // Directed transfers
    xfer(1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 2, 32'h1111_2222, 0);
    xfer(0, 32'h3000_0010, 32'h0, 4'hF, 0, 32'hCAFE_F00D, 0);
    xfer(0, 32'h3000_0020, 32'h0, 4'hF, 1000, 32'hDEAD_BEEF, 0);
    xfer(0, 32'h3000_0024, 32'h0, 4'h3, TO - 1, 32'h1234_5678, 0);
    xfer(1, 32'h3000_0028, 32'h5555_AAAA, 4'h1, TO - 1, 32'h0, 0);
    xfer(0, 32'h3000_0030, 32'h0, 4'hF, 1, 32'h0BAD_F00D, 5);

    // Stray acks while idle must change nothing
    for (int i = 0; i < 3; i++) begin
      ack = 1; dat_i = $urandom;
      cyc_step();
      chk("stray_idle_cyc", cyc, 0);
      chk("stray_idle_rsp", rsp_valid, 0);
      chk("stray_idle_ready", cmd_ready, 1);
    end
    ack = 0;

    // Reset during BUS
    cmd_valid = 1; cmd_we = 0; cmd_adr = 32'h3000_0040; cmd_sel = 4'hF;
    cyc_step();
    cmd_valid = 0;
    cyc_step();
    chk("pre_rst_cyc", cyc, 1);
    rst = 1;
    cyc_step();
    chk("midbus_rst_cyc", cyc, 0);
    chk("midbus_rst_stb", stb, 0);
    chk("midbus_rst_rsp", rsp_valid, 0);
    rst = 0; ack = 1; dat_i = 32'hFFFF_FFFF;
    cyc_step();
    ack = 0;
    chk("post_rst_rsp", rsp_valid, 0);
    chk("post_rst_cyc", cyc, 0);
    chk("post_rst_ready", cmd_ready, 1);

    // Reset during RESP
    cmd_valid = 1; cmd_we = 0; cmd_adr = 32'h3000_0044;
    cyc_step();
    cmd_valid = 0; ack = 1; dat_i = 32'h7777_7777;
    cyc_step();
    ack = 0;
    chk("resp_before_rst", rsp_valid, 1);
    rst = 1;
    cyc_step();
    chk("midresp_rst_rsp", rsp_valid, 0);
    rst = 0;
    cyc_step();
    chk("midresp_post_ready", cmd_ready, 1);

    // Randomized transfers
    for (int t = 0; t < 40; t++) begin
      rd = $urandom;
      xfer(1'($urandom), $urandom, $urandom, SW'($urandom),
           int'($urandom_range(0, TO + 2)), rd, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
